dht_sensor_ctrl: RTL and testbench

Parametrised single-wire controller for DHT11- and DHT22-class humidity/temperature sensors. It sits between the sensor pin and the UART/report logic. It enforces power-up and inter-read hold-off times and generates the host start pulse. It times every bit with microsecond resolution, validates the checksum, and publishes scaled readings with an error code. It supports single-shot and free-running (auto) acquisition.

---
 rtl/dht_sensor_ctrl_if.sv | 25 ++
 rtl/dht_sensor_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dht_sensor_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dht_sensor_ctrl_if.sv
// dht_sensor_ctrl_if: host-side request and result bundle
// for the single-wire humidity/temperature controller.
interface dht_sensor_ctrl_if;
   logic        start;
   logic        auto_en;
   logic        mode;
   logic        busy;
   logic        valid;
   logic [1:0]  error;
   logic [15:0] humidity;
   logic [15:0] temperature;
   logic [39:0] raw_data;

   modport master (
      output start, auto_en, mode,
      input  busy, valid, error,
      input  humidity, temperature, raw_data
   );

   modport slave (
      input  start, auto_en, mode,
      output busy, valid, error,
      output humidity, temperature, raw_data
   );
endinterface

// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: DHT11/DHT22 single-wire acquisition controller.
// Times the protocol in microseconds and publishes scaled readings.
module dht_sensor_ctrl #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int POWERUP_MS    = 1000,
   parameter int INTERVAL11_MS = 1000,
   parameter int INTERVAL22_MS = 2000,
   parameter int START11_US    = 18000,
   parameter int START22_US    = 1100,
   parameter int TIMEOUT_US    = 100,
   parameter int BIT_THRESH_US = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   inout  wire              dht_data,
   dht_sensor_ctrl_if.slave bus
);

   localparam int DIV = CLK_FREQ / 1_000_000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [21:0] PWR_T  = 22'(POWERUP_MS * 1000 - 1);
   localparam logic [21:0] IV11_T = 22'(INTERVAL11_MS * 1000 - 1);
   localparam logic [21:0] IV22_T = 22'(INTERVAL22_MS * 1000 - 1);
   localparam logic [21:0] ST11_T = 22'(START11_US - 1);
   localparam logic [21:0] ST22_T = 22'(START22_US - 1);
   localparam logic [21:0] TMO_T  = 22'(TIMEOUT_US);
   localparam logic [21:0] THR_T  = 22'(BIT_THRESH_US);

   typedef enum logic [3:0] {
      S_POWERUP,
      S_IDLE,
      S_START_LOW,
      S_WAIT_RESP,
      S_RESP_LOW,
      S_RESP_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_CHECK,
      S_DONE,
      S_HOLDOFF
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q;
   logic [21:0]   us_q;
   logic          tick, tmo;
   logic [2:0]    sync_q;
   logic          rise, fall;
   logic          mode_q, pend_q;
   logic [5:0]    bits_q;
   logic [39:0]   shift_q;
   logic          oe_q, busy_q, valid_q;
   logic [1:0]    error_q, err_d;
   logic [15:0]   hum_q, temp_q;
   logic [39:0]   raw_q;
   logic          go, shift_en, upd;
   logic [7:0]    sum;
   logic [15:0]   hum_s, temp_s;

   assign dht_data = oe_q ? 1'b0 : 1'bz;

   assign tick = (pre_q == PRE_MAX);
   assign tmo  = tick && (us_q >= TMO_T);
   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];
   assign sum  = shift_q[39:32] + shift_q[31:24]
               + shift_q[23:16] + shift_q[15:8];

   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.error       = error_q;
   assign bus.humidity    = hum_q;
   assign bus.temperature = temp_q;
   assign bus.raw_data    = raw_q;

   // Line synchronizer plus one stage of history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[1:0], dht_data};
      end
   end

   // Microsecond prescaler and saturating counter, cleared on state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         us_q  <= '0;
      end else if (state_d != state_q) begin
         pre_q <= '0;
         us_q  <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
         if (tick && (us_q != '1)) begin
            us_q <= us_q + 22'd1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_POWERUP;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, error code and capture strobes.
   always_comb begin
      state_d  = state_q;
      err_d    = error_q;
      go       = 1'b0;
      shift_en = 1'b0;
      upd      = 1'b0;
      unique case (state_q)
         S_POWERUP: begin
            if (tick && (us_q >= PWR_T)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (bus.start || pend_q || bus.auto_en) begin
               state_d = S_START_LOW;
               go      = 1'b1;
            end
         end
         S_START_LOW: begin
            if (tick && (us_q >= (mode_q ? ST22_T : ST11_T))) begin
               state_d = S_WAIT_RESP;
            end
         end
         S_WAIT_RESP: begin
            if (fall) begin
               state_d = S_RESP_LOW;
            end else if (tmo) begin
               state_d = S_DONE;
               err_d   = 2'b01;
            end
         end
         S_RESP_LOW: begin
            if (rise) begin
               state_d = S_RESP_HIGH;
            end else if (tmo) begin
               state_d = S_DONE;
               err_d   = 2'b01;
            end
         end
         S_RESP_HIGH: begin
            if (fall) begin
               state_d = S_BIT_LOW;
            end else if (tmo) begin
               state_d = S_DONE;
               err_d   = 2'b01;
            end
         end
         S_BIT_LOW: begin
            if (rise) begin
               state_d = S_BIT_HIGH;
            end else if (tmo) begin
               state_d = S_DONE;
               err_d   = 2'b10;
            end
         end
         S_BIT_HIGH: begin
            if (fall) begin
               shift_en = 1'b1;
               state_d  = (bits_q == 6'd39) ? S_CHECK : S_BIT_LOW;
            end else if (tmo) begin
               state_d = S_DONE;
               err_d   = 2'b10;
            end
         end
         S_CHECK: begin
            state_d = S_DONE;
            if (sum == shift_q[7:0]) begin
               err_d = 2'b00;
               upd   = 1'b1;
            end else begin
               err_d = 2'b11;
            end
         end
         S_DONE: begin
            state_d = S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (tick && (us_q >= (mode_q ? IV22_T : IV11_T))) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_POWERUP;
         end
      endcase
   end

   // Reading scaling: DHT11 integer/decimal bytes, DHT22 sign-magnitude.
   always_comb begin
      hum_s  = shift_q[39:24];
      temp_s = shift_q[23:8];
      if (!mode_q) begin
         hum_s  = 16'(shift_q[39:32]) * 16'd10 + 16'(shift_q[31:24]);
         temp_s = 16'(shift_q[23:16]) * 16'd10 + 16'(shift_q[15:8]);
      end else if (shift_q[23]) begin
         temp_s = 16'd0 - {1'b0, shift_q[22:8]};
      end
   end

   // Request bookkeeping, mode capture and bit shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         mode_q  <= 1'b0;
         bits_q  <= '0;
         shift_q <= '0;
      end else begin
         if (go) begin
            pend_q  <= 1'b0;
            mode_q  <= bus.mode;
            bits_q  <= '0;
            shift_q <= '0;
         end else begin
            if (bus.start &&
                (state_q == S_POWERUP || state_q == S_HOLDOFF)) begin
               pend_q <= 1'b1;
            end
            if (shift_en) begin
               bits_q  <= bits_q + 6'd1;
               shift_q <= {shift_q[38:0], (us_q > THR_T)};
            end
         end
      end
   end

   // Registered outputs; results load only on a good checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         error_q <= 2'b00;
         hum_q   <= '0;
         temp_q  <= '0;
         raw_q   <= '0;
      end else begin
         oe_q    <= (state_d == S_START_LOW);
         busy_q  <= (state_d inside {S_START_LOW, S_WAIT_RESP,
                                     S_RESP_LOW, S_RESP_HIGH,
                                     S_BIT_LOW, S_BIT_HIGH, S_CHECK});
         valid_q <= (state_d == S_DONE);
         error_q <= err_d;
         if (upd) begin
            hum_q  <= hum_s;
            temp_q <= temp_s;
            raw_q  <= shift_q;
         end
      end
   end

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: directed bench with a behavioural sensor.
// One clock is one microsecond so protocol times read as cycles.
module tb_dht_sensor_ctrl;

   localparam int P = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   wire         dht_line;
   logic        s_drv = 1'b0;
   logic [39:0] s_frame = '0;
   int          s_bits = 0;
   longint      t_fall = 0, t_rel = 0, low_us = 0;
   longint      t_ev = 0, t_done = 0;
   longint      b1, b2, b3, v1, d1, d2, rd;
   int          total = 0, bad = 0;
   int          nvalid = 0, nrise = 0, rise0 = 0;
   logic        busy_p = 1'b0;

   assign dht_line = s_drv ? 1'b0 : 1'bz;
   pullup (dht_line);

   always #5 clk = ~clk;

   dht_sensor_ctrl_if bus_if ();

   dht_sensor_ctrl #(
      .CLK_FREQ     (1_000_000),
      .POWERUP_MS   (1),
      .INTERVAL11_MS(2),
      .INTERVAL22_MS(3),
      .START11_US   (1800),
      .START22_US   (1100),
      .TIMEOUT_US   (100),
      .BIT_THRESH_US(40)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dht_data(dht_line),
      .bus     (bus_if)
   );

   // Count valid pulses and busy rising edges.
   always @(posedge clk) begin
      if (bus_if.valid) nvalid <= nvalid + 1;
      busy_p <= bus_if.busy;
      if (bus_if.busy && !busy_p) nrise <= nrise + 1;
   end

   // Sensor: measure host pulse, then answer with s_bits bits.
   initial begin
      wait (rst_n === 1'b1);
      forever begin
         @(negedge dht_line);
         t_fall = $time;
         @(posedge dht_line);
         t_rel  = $time;
         low_us = (t_rel - t_fall) / P;
         if (s_bits > 0 && rst_n === 1'b1) begin
            #(30 * P + 3);
            s_drv = 1'b1;
            #(80 * P);
            s_drv = 1'b0;
            #(80 * P);
            for (int i = 0; i < s_bits; i++) begin
               s_drv = 1'b1;
               #(50 * P);
               s_drv = 1'b0;
               #((s_frame[39 - i] ? 70 : 26) * P);
            end
            if (s_bits == 40) begin
               s_drv = 1'b1;
               #(50 * P);
               s_drv = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input longint obs,
                          input longint lo, input longint hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d",
                tag, obs, lo, hi);
      end
   endtask

   task automatic wait_busy(input string tag, input int lim);
      int n = 0;
      while (!bus_if.busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      t_ev = $time;
      chk(tag, bus_if.busy, 1);
   endtask

   task automatic wait_valid(input string tag, input int lim);
      int n = 0;
      while (!bus_if.valid && n < lim) begin
         @(negedge clk);
         n++;
      end
      t_ev = $time;
      chk(tag, bus_if.valid, 1);
   endtask

   initial begin
      bus_if.start   = 1'b0;
      bus_if.auto_en = 1'b0;
      bus_if.mode    = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_valid", bus_if.valid, 0);
      chk("rst_error", bus_if.error, 0);
      chk("rst_hum", bus_if.humidity, 0);
      chk("rst_temp", bus_if.temperature, 0);
      chk("rst_raw", bus_if.raw_data, 0);
      chk("rst_line", dht_line, 1);
      rst_n = 1'b1;

      // DHT11 good frame, requested during power-up
      @(negedge clk);
      s_frame = 40'h3700190555;
      s_bits  = 40;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pwr_busy", bus_if.busy, 0);
      wait_busy("r1_start", 1100);
      wait_valid("r1_done", 8000);
      chk("r1_err", bus_if.error, 0);
      chk("r1_hum", bus_if.humidity, 550);
      chk("r1_temp", bus_if.temperature, 255);
      chk("r1_raw", bus_if.raw_data, 40'h3700190555);
      chk_rng("r1_low", low_us, 1799, 1801);
      repeat (50) @(negedge clk);
      chk("r1_nvalid", nvalid, 1);

      // DHT11 bad checksum
      s_frame = 40'h3700190554;
      bus_if.start = 1'b1;
      wait_busy("r2_start", 3000);
      bus_if.start = 1'b0;
      wait_valid("r2_done", 8000);
      chk("r2_err", bus_if.error, 3);
      chk("r2_hum", bus_if.humidity, 550);
      chk("r2_temp", bus_if.temperature, 255);
      chk("r2_raw", bus_if.raw_data, 40'h3700190555);

      // DHT22 silent sensor
      s_bits = 0;
      bus_if.mode = 1'b1;
      bus_if.start = 1'b1;
      wait_busy("r3_start", 3000);
      bus_if.start = 1'b0;
      wait_valid("r3_done", 3000);
      chk("r3_err", bus_if.error, 1);
      chk_rng("r3_tmo", (t_ev - t_rel) / P, 100, 101);
      chk("r3_busy", bus_if.busy, 0);
      chk("r3_line", dht_line, 1);

      // DHT11 sensor stops after 20 bits
      s_frame = 40'h3700190555;
      s_bits  = 20;
      bus_if.mode = 1'b0;
      bus_if.start = 1'b1;
      wait_busy("r4_start", 4000);
      bus_if.start = 1'b0;
      wait_valid("r4_done", 6000);
      t_done = t_ev;
      chk("r4_err", bus_if.error, 2);
      chk("r4_raw", bus_if.raw_data, 40'h3700190555);
      chk("r4_hum", bus_if.humidity, 550);

      // start held through hold-off: exactly one more read
      s_frame = 40'h41001A035E;
      s_bits  = 40;
      rise0   = nrise;
      bus_if.start = 1'b1;
      wait_busy("r5_start", 2500);
      chk_rng("r5_gap", (t_ev - t_done) / P, 2000, 2003);
      bus_if.start = 1'b0;
      wait_valid("r5_done", 8000);
      chk("r5_err", bus_if.error, 0);
      chk("r5_hum", bus_if.humidity, 650);
      chk("r5_temp", bus_if.temperature, 263);
      chk("r5_raw", bus_if.raw_data, 40'h41001A035E);
      repeat (2200) @(negedge clk);
      chk("r5_one_read", nrise - rise0, 1);
      chk("r5_idle", bus_if.busy, 0);

      // DHT22 free-running reads
      s_frame = 40'h028C806573;
      bus_if.mode = 1'b1;
      bus_if.auto_en = 1'b1;
      wait_busy("a1_start", 10);
      b1 = t_ev;
      wait_valid("a1_done", 8000);
      v1 = t_ev;
      chk("a1_err", bus_if.error, 0);
      chk("a1_hum", bus_if.humidity, 16'h028C);
      chk("a1_temp", bus_if.temperature, 16'hFF9B);
      chk("a1_raw", bus_if.raw_data, 40'h028C806573);
      chk_rng("a1_low", low_us, 1099, 1101);
      wait_busy("a2_start", 4000);
      b2 = t_ev;
      wait_valid("a2_done", 8000);
      wait_busy("a3_start", 4000);
      b3 = t_ev;
      d1 = (b2 - b1) / P;
      d2 = (b3 - b2) / P;
      rd = (v1 - b1) / P;
      chk("auto_even", d2, d1);
      chk_rng("auto_gap", d1, rd + 3000, rd + 3003);

      // reset in the middle of the host low pulse
      s_bits = 0;
      repeat (500) @(negedge clk);
      chk("a3_low", dht_line, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_line", dht_line, 1);
      chk("rst2_busy", bus_if.busy, 0);
      chk("rst2_valid", bus_if.valid, 0);
      chk("rst2_error", bus_if.error, 0);
      chk("rst2_hum", bus_if.humidity, 0);
      chk("rst2_temp", bus_if.temperature, 0);
      chk("rst2_raw", bus_if.raw_data, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
